// File: rtl/btn_step_seq.sv
// Debounces N_STAGES active-low buttons and steps a one-hot LED stage indicator (strict order or free fwd/back).
// Latency: DEBOUNCE_CYCLES+4 clk edges from a stable button low to the updated led/stage/wrap.
// Backpressure: none; button inputs are sampled every cycle and outputs are always valid.
module btn_step_seq #(
  parameter int N_STAGES        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_STAGES-1:0]         btn,
  input  logic                        mode,
  output logic [N_STAGES-1:0]         led,
  output logic [$clog2(N_STAGES)-1:0] stage,
  output logic                        wrap
);

  localparam int SW = $clog2(N_STAGES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] ONE = {{(N_STAGES-1){1'b0}}, 1'b1};

  logic [N_STAGES-1:0] sync1, sync2, deb, deb_d, press;
  logic [CW-1:0]       cnt [N_STAGES];
  logic [SW-1:0]       idx, idx_nxt;
  logic                wrap_nxt;
  logic                cur_press;

  // Per-button synchroniser, debounce counter and falling-edge press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int i = 0; i < N_STAGES; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int i = 0; i < N_STAGES; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    idx_nxt   = idx;
    wrap_nxt  = 1'b0;
    cur_press = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (idx == SW'(i)) cur_press = press[i];
    end
    if (!mode) begin
      if (cur_press) begin
        if (idx == LAST) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + SW'(1);
        end
      end
    end else if (press[0] && !press[1]) begin
      if (idx == LAST) begin
        idx_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx + SW'(1);
      end
    end else if (press[1] && !press[0]) begin
      // Backward step from stage 0 lands on the last stage.
      if (idx == '0) begin
        idx_nxt  = LAST;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx - SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      led  <= ONE;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      led  <= ONE << idx_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign stage = idx;

endmodule

// File: tb/tb_btn_step_seq.sv
// Directed bench for btn_step_seq with N_STAGES=4, DEBOUNCE_CYCLES=4; inputs change and outputs are sampled on the falling edge.
module tb_btn_step_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       mode;
  logic [3:0] led;
  logic [1:0] stage;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  btn_step_seq #(.N_STAGES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .mode  (mode),
    .led   (led),
    .stage (stage),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_led, input logic [1:0] e_stage,
                         input logic e_wrap);
    chk({tag, "_led"},   32'(led),   32'(e_led));
    chk({tag, "_stage"}, 32'(stage), 32'(e_stage));
    chk({tag, "_wrap"},  32'(wrap),  32'(e_wrap));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst", 4'b0001, 2'd0, 1'b0);
  endtask

  // Press the buttons in mask together, hold well past the step, then release fully.
  task automatic do_press(input string tag, input logic [3:0] mask, input logic [3:0] prev_led,
                          input logic [3:0] e_led, input logic [1:0] e_stage, input logic e_wrap);
    btn = btn & ~mask;
    repeat (7) tick();
    chk({tag, "_e7_led"}, 32'(led), 32'(prev_led));
    tick();
    chk_out({tag, "_e8"}, e_led, e_stage, e_wrap);
    tick();
    chk({tag, "_e9_wrap"}, 32'(wrap), 32'd0);
    repeat (10) tick();
    chk({tag, "_hold_led"}, 32'(led), 32'(e_led));
    btn = btn | mask;
    repeat (12) tick();
    chk({tag, "_rel_stage"}, 32'(stage), 32'(e_stage));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    btn  = 4'hF;
    mode = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    tick();
    do_reset();

    // Idle: nothing moves.
    for (int c = 0; c < 50; c++) begin
      tick();
      chk_out("idle", 4'b0001, 2'd0, 1'b0);
    end

    // Strict mode: hold btn0, then an out-of-order btn2 is ignored.
    do_press("s_b0", 4'b0001, 4'b0001, 4'b0010, 2'd1, 1'b0);
    do_press("s_b2_ign", 4'b0100, 4'b0010, 4'b0010, 2'd1, 1'b0);

    // Strict full sequence with wrap on the last step.
    do_reset();
    do_press("seq0", 4'b0001, 4'b0001, 4'b0010, 2'd1, 1'b0);
    do_press("seq1", 4'b0010, 4'b0010, 4'b0100, 2'd2, 1'b0);
    do_press("seq2", 4'b0100, 4'b0100, 4'b1000, 2'd3, 1'b0);
    do_press("seq3", 4'b1000, 4'b1000, 4'b0001, 2'd0, 1'b1);

    // Bounce: 3 low / 1 high four times never completes a debounce.
    for (int k = 0; k < 4; k++) begin
      btn[0] = 1'b0;
      repeat (3) tick();
      btn[0] = 1'b1;
      tick();
    end
    chk_out("bnc_during", 4'b0001, 2'd0, 1'b0);
    btn[0] = 1'b0;
    repeat (7) tick();
    chk("bnc_e7_led", 32'(led), 32'(4'b0001));
    tick();
    chk_out("bnc_e8", 4'b0010, 2'd1, 1'b0);
    repeat (10) tick();
    btn[0] = 1'b1;
    repeat (12) tick();
    chk("bnc_once", 32'(stage), 32'd1);

    // Free mode: backward wrap, simultaneous no-op, ignored btn2, forward wrap.
    do_reset();
    mode = 1'b1;
    do_press("f_back", 4'b0010, 4'b0001, 4'b1000, 2'd3, 1'b1);
    do_press("f_both", 4'b0011, 4'b1000, 4'b1000, 2'd3, 1'b0);
    do_press("f_b2_ign", 4'b0100, 4'b1000, 4'b1000, 2'd3, 1'b0);
    do_press("f_fwd_wrap", 4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1);
    do_press("f_fwd", 4'b0001, 4'b0001, 4'b0010, 2'd1, 1'b0);

    // Mode change keeps the stage; strict then continues from it.
    mode = 1'b0;
    tick();
    chk_out("mode_keep", 4'b0010, 2'd1, 1'b0);
    do_press("m_b1", 4'b0010, 4'b0010, 4'b0100, 2'd2, 1'b0);

    // Reset while btn0 is mid-debounce (counter at 2), button kept held.
    btn[0] = 1'b0;
    repeat (4) tick();
    chk("mid_pre_stage", 32'(stage), 32'd2);
    do_reset();
    repeat (7) tick();
    chk_out("mid_e7", 4'b0001, 2'd0, 1'b0);
    tick();
    chk_out("mid_e8", 4'b0010, 2'd1, 1'b0);
    repeat (10) tick();
    chk("mid_hold", 32'(stage), 32'd1);
    btn[0] = 1'b1;
    repeat (12) tick();
    chk("mid_rel", 32'(stage), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
